mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 84 ++++++++
 tb/tb_mem_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a multi-cycle data memory, stall FSM and MEM/WB register.
// Ports: clock, reset (async, active-high); EX/MEM control/address/store data in;
//        registered MEM/WB outputs; combinational forwarding copies and MemStall.
module mem_stage #(
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        EXMEMRegWrite,
  input  logic        EXMEMMemtoReg,
  input  logic        EXMEMMemRead,
  input  logic        EXMEMMemWrite,
  input  logic [31:0] EXMEMReadAddress,
  input  logic [31:0] EXMEMWriteData,
  input  logic [4:0]  EXMEMDst,
  output logic        MEMWBRegWrite,
  output logic        MEMWBMemtoReg,
  output logic [31:0] MEMWBReadData,
  output logic [31:0] MEMWBALUResult,
  output logic [4:0]  MEMWBDst,
  output logic [31:0] MEMForwarding,
  output logic        EXMEMRegWriteOut,
  output logic [4:0]  EXMEMDstOut,
  output logic        MemStall
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [31:0] mem [MEM_WORDS];
  logic access, done;
  logic [AW-1:0] idx;
  logic [31:0] load_data;
  assign access = EXMEMMemRead | EXMEMMemWrite;
  assign done = access & ~MemStall;
  assign idx = EXMEMReadAddress[AW+1:2];
  // a simultaneous read and write returns the data being stored
  assign load_data = EXMEMMemWrite ? EXMEMWriteData : mem[idx];
  assign MEMForwarding = EXMEMReadAddress;
  assign EXMEMRegWriteOut = EXMEMRegWrite;
  assign EXMEMDstOut = EXMEMDst;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    MemStall = 1'b0;
    if (state == WAIT) begin
      MemStall = cnt != 3'd0;
      state_nx = MemStall ? WAIT : IDLE;
      cnt_nx = MemStall ? cnt - 3'd1 : 3'd0;
    end else if (access && MEM_LATENCY != 0) begin
      MemStall = 1'b1;
      state_nx = WAIT;
      cnt_nx = 3'(MEM_LATENCY - 1);
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= 3'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // the reset guard keeps a zero-latency store from landing while reset is held
  always_ff @(posedge clock)
    if (done && EXMEMMemWrite && !reset) mem[idx] <= EXMEMWriteData;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      MEMWBRegWrite <= 1'b0;
      MEMWBMemtoReg <= 1'b0;
      MEMWBReadData <= 32'd0;
      MEMWBALUResult <= 32'd0;
      MEMWBDst <= 5'd0;
    end else begin
      MEMWBRegWrite <= EXMEMRegWrite & ~MemStall;
      MEMWBMemtoReg <= EXMEMMemtoReg & ~MemStall;
      if (!MemStall) begin
        MEMWBALUResult <= EXMEMReadAddress;
        MEMWBDst <= EXMEMDst;
        if (EXMEMMemRead) MEMWBReadData <= load_data;
      end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: checks mem_stage at latency 2 and latency 0 against a transaction-level model.
module tb_mem_stage;
  localparam int LAT = 2;
  typedef struct packed {
    logic rw, m2r, rd, wr;
    logic [31:0] addr, wd;
    logic [4:0] dst;
  } in_t;
  typedef struct {
    logic rw, m2r;
    logic [31:0] rd, alu;
    logic [4:0] dst;
  } exp_t;
  typedef struct {
    int s;
    in_t i;
    logic rw, m2r;
    logic [31:0] rd, alu;
    logic [4:0] dst;
  } vec_t;
  logic clock = 1'b0;
  logic reset;
  in_t a, z;
  logic a_rw, a_m2r, a_rwo, a_stall, z_rw, z_m2r, z_rwo, z_stall;
  logic [31:0] a_rd, a_alu, a_fwd, z_rd, z_alu, z_fwd;
  logic [4:0] a_dst, a_dsto, z_dst, z_dsto;
  int checks = 0;
  int errors = 0;
  logic [31:0] mm [2][256];
  exp_t e [2];
  vec_t vt [11];
  always #5 clock = ~clock;
  mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(LAT)) da (
    .clock(clock), .reset(reset),
    .EXMEMRegWrite(a.rw), .EXMEMMemtoReg(a.m2r), .EXMEMMemRead(a.rd), .EXMEMMemWrite(a.wr),
    .EXMEMReadAddress(a.addr), .EXMEMWriteData(a.wd), .EXMEMDst(a.dst),
    .MEMWBRegWrite(a_rw), .MEMWBMemtoReg(a_m2r), .MEMWBReadData(a_rd), .MEMWBALUResult(a_alu),
    .MEMWBDst(a_dst), .MEMForwarding(a_fwd), .EXMEMRegWriteOut(a_rwo), .EXMEMDstOut(a_dsto),
    .MemStall(a_stall)
  );
  mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(0)) dz (
    .clock(clock), .reset(reset),
    .EXMEMRegWrite(z.rw), .EXMEMMemtoReg(z.m2r), .EXMEMMemRead(z.rd), .EXMEMMemWrite(z.wr),
    .EXMEMReadAddress(z.addr), .EXMEMWriteData(z.wd), .EXMEMDst(z.dst),
    .MEMWBRegWrite(z_rw), .MEMWBMemtoReg(z_m2r), .MEMWBReadData(z_rd), .MEMWBALUResult(z_alu),
    .MEMWBDst(z_dst), .MEMForwarding(z_fwd), .EXMEMRegWriteOut(z_rwo), .EXMEMDstOut(z_dsto),
    .MemStall(z_stall)
  );
  function automatic in_t mk(logic rw, logic m2r, logic rd, logic wr,
                             logic [31:0] addr, logic [31:0] wd, logic [4:0] dst);
    in_t t;
    t.rw = rw; t.m2r = m2r; t.rd = rd; t.wr = wr;
    t.addr = addr; t.wd = wd; t.dst = dst;
    return t;
  endfunction
  // one edge of the reference: a stalled edge only bubbles, a completing edge retires the instruction
  function automatic void apply(int s, in_t t, bit st);
    if (st) begin
      e[s].rw = 1'b0;
      e[s].m2r = 1'b0;
    end else begin
      e[s].rw = t.rw;
      e[s].m2r = t.m2r;
      e[s].alu = t.addr;
      e[s].dst = t.dst;
      if (t.wr) mm[s][t.addr[9:2]] = t.wd;
      if (t.rd) e[s].rd = mm[s][t.addr[9:2]];
    end
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic chk_out(int s);
    chk("memwb_regwrite", s ? z_rw : a_rw, e[s].rw);
    chk("memwb_memtoreg", s ? z_m2r : a_m2r, e[s].m2r);
    chk("memwb_readdata", s ? z_rd : a_rd, e[s].rd);
    chk("memwb_aluresult", s ? z_alu : a_alu, e[s].alu);
    chk("memwb_dst", s ? z_dst : a_dst, e[s].dst);
  endtask
  // drives one instruction into DUT s until it retires; the other DUT sees idle bubbles
  task automatic txn(int s, in_t t);
    int n;
    n = ((t.rd || t.wr) && s == 0) ? LAT + 1 : 1;
    if (s == 1) begin z = t; a = '0; end else begin a = t; z = '0; end
    for (int k = 0; k < n; k++) begin
      #1;
      chk("mem_stall", s ? z_stall : a_stall, k < n - 1);
      chk("forwarding", s ? z_fwd : a_fwd, t.addr);
      chk("regwrite_out", s ? z_rwo : a_rwo, t.rw);
      chk("dst_out", s ? z_dsto : a_dsto, t.dst);
      @(posedge clock);
      apply(s, t, k < n - 1);
      apply(1 - s, '0, 1'b0);
      #1;
      chk_out(s);
    end
  endtask
  initial begin
    vt[0]  = '{0, mk(0,0,0,1, 32'h10,  32'hDEADBEEF, 0), 0, 0, 32'h0,        32'h10,  0};
    vt[1]  = '{0, mk(1,1,1,0, 32'h10,  32'h0,        5), 1, 1, 32'hDEADBEEF, 32'h10,  5};
    vt[2]  = '{0, mk(0,0,0,1, 32'h400, 32'h1234,     0), 0, 0, 32'hDEADBEEF, 32'h400, 0};
    vt[3]  = '{0, mk(1,1,1,0, 32'h0,   32'h0,        7), 1, 1, 32'h1234,     32'h0,   7};
    vt[4]  = '{0, mk(0,0,1,1, 32'h20,  32'h55,       2), 0, 0, 32'h55,       32'h20,  2};
    vt[5]  = '{0, mk(1,1,1,0, 32'h20,  32'h0,        9), 1, 1, 32'h55,       32'h20,  9};
    vt[6]  = '{0, mk(1,0,0,0, 32'h7,   32'h0,        3), 1, 0, 32'h55,       32'h7,   3};
    vt[7]  = '{1, mk(1,1,1,0, 32'h4,   32'h0,        1), 1, 1, 32'h0,        32'h4,   1};
    vt[8]  = '{1, mk(1,0,0,0, 32'h99,  32'h0,        2), 1, 0, 32'h0,        32'h99,  2};
    vt[9]  = '{1, mk(0,0,0,1, 32'h4,   32'hCAFE,     0), 0, 0, 32'h0,        32'h4,   0};
    vt[10] = '{1, mk(1,1,1,0, 32'h4,   32'h0,        4), 1, 1, 32'hCAFE,     32'h4,   4};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) mm[s][i] = 32'h0;
      e[s] = '{default: '0};
    end
    reset = 1'b1;
    a = '0;
    z = '0;
    #3;
    chk_out(0);
    chk_out(1);
    chk("reset_stall_idle", a_stall, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    foreach (vt[i]) begin
      txn(vt[i].s, vt[i].i);
      chk("vec_regwrite", vt[i].s ? z_rw : a_rw, vt[i].rw);
      chk("vec_memtoreg", vt[i].s ? z_m2r : a_m2r, vt[i].m2r);
      chk("vec_readdata", vt[i].s ? z_rd : a_rd, vt[i].rd);
      chk("vec_aluresult", vt[i].s ? z_alu : a_alu, vt[i].alu);
      chk("vec_dst", vt[i].s ? z_dst : a_dst, vt[i].dst);
    end
    a = mk(0,0,0,1, 32'h30, 32'hAA, 0);
    z = '0;
    #1 chk("abort_stall0", a_stall, 1);
    @(posedge clock);
    apply(0, a, 1'b1);
    apply(1, '0, 1'b0);
    #1 chk("abort_stall1", a_stall, 1);
    reset = 1'b1;
    e[0] = '{default: '0};
    e[1] = '{default: '0};
    #1;
    chk_out(0);
    chk_out(1);
    chk("reset_stall_access", a_stall, 1);
    @(posedge clock);
    #1 chk_out(0);
    a = '0;
    reset = 1'b0;
    txn(0, mk(1,1,1,0, 32'h30, 32'h0, 6));
    chk("abort_no_store", a_rd, 32'h0);
    for (int i = 0; i < 300; i++)
      txn(int'($urandom_range(0, 1)),
          mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom & 32'h0000_0FFF, $urandom, 5'($urandom)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
